// File: rtl/face_pkg.sv
// Shared definitions for the face pixel source: blink FSM state encodings,
// RGB565 colour defaults and panel dimensions used by every pixel source.
package face_pkg;

    typedef enum logic [1:0] {
        S_OPEN    = 2'd0,
        S_CLOSING = 2'd1,
        S_CLOSED  = 2'd2,
        S_OPENING = 2'd3
    } blink_state_t;

    localparam logic [15:0] BG_COLOR_DEFAULT = 16'h2935;
    localparam logic [15:0] FG_COLOR_DEFAULT = 16'hFFFF;

    localparam int unsigned LCD_W_DEFAULT = 132;
    localparam int unsigned LCD_H_DEFAULT = 162;

endpackage

// File: rtl/circle_hit.sv
// Combinational eye test: a pixel is lit when it lies inside the circle of
// radius r around (cx, cy) and within h rows of the centre, so shrinking h
// squashes the round eye into a horizontal slit.
module circle_hit (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [3:0] r,
    input  logic [3:0] h,
    output logic       hit
);

    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [7:0]        adx;
    logic [7:0]        ady;
    logic [15:0]       dx2;
    logic [15:0]       dy2;
    logic [15:0]       r2;
    logic [16:0]       dist2;

    // Signed offsets, magnitudes and squared distance compared against r^2.
    always_comb begin
        dx    = $signed({1'b0, x}) - $signed({1'b0, cx});
        dy    = $signed({1'b0, y}) - $signed({1'b0, cy});
        adx   = dx[8] ? 8'(-dx) : dx[7:0];
        ady   = dy[8] ? 8'(-dy) : dy[7:0];
        dx2   = 16'(adx) * 16'(adx);
        dy2   = 16'(ady) * 16'(ady);
        r2    = 16'(r) * 16'(r);
        // Sum kept one bit wider so far-away pixels cannot wrap into a hit.
        dist2 = 17'(dx2) + 17'(dy2);
        hit   = (dist2 <= 17'(r2)) && (ady <= 8'(h));
    end

endmodule

// File: rtl/blink_face_gen.sv
// Face pixel source: returns the registered RGB565 colour of the pixel at
// the LCD scan address and animates eye blinks that only change state at
// frame starts, so each frame is drawn with a single eye height.
module blink_face_gen
    import face_pkg::*;
#(
    parameter int unsigned LCD_W        = LCD_W_DEFAULT,
    parameter int unsigned LCD_H        = LCD_H_DEFAULT,
    parameter logic [15:0] BG_COLOR     = BG_COLOR_DEFAULT,
    parameter logic [15:0] FG_COLOR     = FG_COLOR_DEFAULT,
    parameter int unsigned EYE_L_X      = 40,
    parameter int unsigned EYE_R_X      = 92,
    parameter int unsigned EYE_Y        = 60,
    parameter int unsigned EYE_R        = 12,
    parameter int unsigned MOUTH_X0     = 36,
    parameter int unsigned MOUTH_X1     = 96,
    parameter int unsigned MOUTH_Y0     = 110,
    parameter int unsigned MOUTH_Y1     = 116,
    parameter int unsigned OPEN_FRAMES  = 90,
    parameter int unsigned PHASE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ram_addr_x,
    input  logic [7:0]  ram_addr_y,
    input  logic        go,
    output logic [15:0] ram_data,
    output logic        frame_tick,
    output logic [1:0]  blink_state
);

    localparam logic [7:0] PANEL_W    = 8'(LCD_W);
    localparam logic [7:0] LAST_ROW   = 8'(LCD_H - 1);
    localparam logic [7:0] EYE_LX     = 8'(EYE_L_X);
    localparam logic [7:0] EYE_RX     = 8'(EYE_R_X);
    localparam logic [7:0] EYE_CY     = 8'(EYE_Y);
    localparam logic [3:0] EYE_RAD    = 4'(EYE_R);
    localparam logic [3:0] EYE_HALF   = 4'(EYE_R >> 1);
    localparam logic [7:0] MX0        = 8'(MOUTH_X0);
    localparam logic [7:0] MX1        = 8'(MOUTH_X1);
    localparam logic [7:0] MY0        = 8'(MOUTH_Y0);
    localparam logic [7:0] MY1        = 8'(MOUTH_Y1);
    localparam logic [7:0] OPEN_LAST  = 8'(OPEN_FRAMES - 1);
    localparam logic [7:0] PHASE_LAST = 8'(PHASE_FRAMES - 1);

    blink_state_t state_q, state_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         go_pending_q, go_pending_d;
    logic [7:0]   prev_y;
    logic [3:0]   eye_h;
    logic         hit_l, hit_r, in_panel, in_mouth;
    logic [15:0]  pix_d;

    assign blink_state = state_q;

    // Frame start detect: registered tick on the last-row to row-0 wrap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            prev_y     <= '0;
            frame_tick <= 1'b0;
        end else begin
            prev_y     <= ram_addr_y;
            frame_tick <= (prev_y == LAST_ROW) && (ram_addr_y == 8'd0);
        end
    end

    // Blink state, frame counter and pending go request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OPEN;
            frame_cnt_q  <= '0;
            go_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            go_pending_q <= go_pending_d;
        end
    end

    // Next-state logic, evaluated only on frame ticks; a go seen in the same
    // cycle as the clearing tick survives and starts the following blink.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        go_pending_d = go_pending_q | go;
        if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            unique case (state_q)
                S_OPEN: begin
                    if ((frame_cnt_q == OPEN_LAST) || go_pending_q) begin
                        state_d      = S_CLOSING;
                        frame_cnt_d  = '0;
                        go_pending_d = go;
                    end
                end
                S_CLOSING: begin
                    if (frame_cnt_q == PHASE_LAST) begin
                        state_d     = S_CLOSED;
                        frame_cnt_d = '0;
                    end
                end
                S_CLOSED: begin
                    if (frame_cnt_q == PHASE_LAST) begin
                        state_d     = S_OPENING;
                        frame_cnt_d = '0;
                    end
                end
                S_OPENING: begin
                    if (frame_cnt_q == PHASE_LAST) begin
                        state_d     = S_OPEN;
                        frame_cnt_d = '0;
                    end
                end
                default: state_d = S_OPEN;
            endcase
        end
    end

    // Eye half-height derived from the registered blink state.
    always_comb begin
        unique case (state_q)
            S_OPEN:    eye_h = EYE_RAD;
            S_CLOSED:  eye_h = 4'd1;
            default:   eye_h = EYE_HALF;
        endcase
    end

    circle_hit u_eye_l (
        .x   (ram_addr_x),
        .y   (ram_addr_y),
        .cx  (EYE_LX),
        .cy  (EYE_CY),
        .r   (EYE_RAD),
        .h   (eye_h),
        .hit (hit_l)
    );

    circle_hit u_eye_r (
        .x   (ram_addr_x),
        .y   (ram_addr_y),
        .cx  (EYE_RX),
        .cy  (EYE_CY),
        .r   (EYE_RAD),
        .h   (eye_h),
        .hit (hit_r)
    );

    assign in_panel = (ram_addr_x < PANEL_W) && (ram_addr_y <= LAST_ROW);
    assign in_mouth = (ram_addr_x >= MX0) && (ram_addr_x <= MX1) &&
                      (ram_addr_y >= MY0) && (ram_addr_y <= MY1);

    // Colour select: foreground for any lit feature inside the panel.
    always_comb begin
        pix_d = BG_COLOR;
        if (in_panel && (hit_l || hit_r || in_mouth)) begin
            pix_d = FG_COLOR;
        end
    end

    // Output register: one cycle of latency from address to colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_data <= BG_COLOR;
        end else begin
            ram_data <= pix_d;
        end
    end

endmodule

// File: tb/tb_blink_face_gen.sv
// Directed bench for blink_face_gen: a pixel vector table per blink state
// plus hand-written frame sequences for blink timing, go and reset.
module tb_blink_face_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ram_addr_x;
    logic [7:0]  ram_addr_y;
    logic        go;
    logic [15:0] ram_data;
    logic        frame_tick;
    logic [1:0]  blink_state;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp_data;
    } pix_vec_t;

    pix_vec_t vecs [28];

    always #5 clk = ~clk;

    blink_face_gen dut (
        .clk         (clk),
        .rst         (rst),
        .ram_addr_x  (ram_addr_x),
        .ram_addr_y  (ram_addr_y),
        .go          (go),
        .ram_data    (ram_data),
        .frame_tick  (frame_tick),
        .blink_state (blink_state)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pix(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ram_addr_x = vecs[i].x;
            ram_addr_y = vecs[i].y;
            step();
            check($sformatf("pix%0d(%0d,%0d)", i, vecs[i].x, vecs[i].y), ram_data, vecs[i].exp_data);
        end
    endtask

    // One compact frame boundary: row 161, then row 0 held for two cycles.
    task automatic do_frame(input logic go_at_tick);
        ram_addr_y = 8'd161;
        step();
        ram_addr_y = 8'd0;
        step();
        check("tick_on_wrap", {15'd0, frame_tick}, 16'd1);
        go = go_at_tick;
        step();
        go = 1'b0;
        check("tick_steady_y", {15'd0, frame_tick}, 16'd0);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) do_frame(1'b0);
    endtask

    task automatic pulse_go();
        ram_addr_y = 8'd50;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
    endtask

    task automatic check_state(input string name, input logic [1:0] exp);
        check(name, {14'd0, blink_state}, {14'd0, exp});
    endtask

    initial begin
        // Open eyes (h=12)
        vecs[0]  = '{8'd40,  8'd60,  16'hFFFF};
        vecs[1]  = '{8'd0,   8'd0,   16'h2935};
        vecs[2]  = '{8'd60,  8'd112, 16'hFFFF};
        vecs[3]  = '{8'd40,  8'd73,  16'h2935};
        vecs[4]  = '{8'd200, 8'd10,  16'h2935};
        vecs[5]  = '{8'd36,  8'd110, 16'hFFFF};
        vecs[6]  = '{8'd96,  8'd116, 16'hFFFF};
        vecs[7]  = '{8'd97,  8'd116, 16'h2935};
        vecs[8]  = '{8'd35,  8'd110, 16'h2935};
        vecs[9]  = '{8'd92,  8'd60,  16'hFFFF};
        vecs[10] = '{8'd104, 8'd60,  16'hFFFF};
        vecs[11] = '{8'd105, 8'd60,  16'h2935};
        vecs[12] = '{8'd40,  8'd48,  16'hFFFF};
        vecs[13] = '{8'd40,  8'd66,  16'hFFFF};
        vecs[14] = '{8'd40,  8'd67,  16'hFFFF};
        vecs[15] = '{8'd48,  8'd69,  16'h2935};
        vecs[16] = '{8'd47,  8'd69,  16'hFFFF};
        // Closing (h=6)
        vecs[17] = '{8'd40,  8'd66,  16'hFFFF};
        vecs[18] = '{8'd40,  8'd67,  16'h2935};
        // Closed (h=1)
        vecs[19] = '{8'd40,  8'd60,  16'hFFFF};
        vecs[20] = '{8'd40,  8'd61,  16'hFFFF};
        vecs[21] = '{8'd40,  8'd62,  16'h2935};
        vecs[22] = '{8'd28,  8'd60,  16'hFFFF};
        vecs[23] = '{8'd40,  8'd59,  16'hFFFF};
        vecs[24] = '{8'd40,  8'd58,  16'h2935};
        vecs[25] = '{8'd60,  8'd112, 16'hFFFF};
        // Opening (h=6)
        vecs[26] = '{8'd40,  8'd54,  16'hFFFF};
        vecs[27] = '{8'd40,  8'd53,  16'h2935};

        rst = 1'b1;
        go = 1'b0;
        ram_addr_x = 8'd40;
        ram_addr_y = 8'd60;
        step();
        step();
        check("reset_data",  ram_data, 16'h2935);
        check("reset_tick",  {15'd0, frame_tick}, 16'd0);
        check_state("reset_state", 2'd0);
        rst = 1'b0;

        run_pix(0, 16);

        // Wrap from a row other than the last must not tick.
        ram_addr_y = 8'd160;
        step();
        ram_addr_y = 8'd0;
        step();
        step();
        check("no_tick_from_160", {15'd0, frame_tick}, 16'd0);

        // Automatic blink timing from reset.
        run_frames(89);
        check_state("auto_f89_open", 2'd0);
        do_frame(1'b0);
        check_state("auto_f90_closing", 2'd1);
        run_pix(17, 18);
        run_frames(2);
        check_state("auto_f92_closing", 2'd1);
        do_frame(1'b0);
        check_state("auto_f93_closed", 2'd2);
        run_pix(19, 25);
        run_frames(3);
        check_state("auto_f96_opening", 2'd3);
        run_pix(26, 27);
        run_frames(2);
        check_state("auto_f98_opening", 2'd3);
        do_frame(1'b0);
        check_state("auto_f99_open", 2'd0);

        // go mid-frame at open frame 10; auto blink restarts 90 frames later.
        run_frames(10);
        check_state("go_f10_open", 2'd0);
        pulse_go();
        check_state("go_waits_tick", 2'd0);
        do_frame(1'b0);
        check_state("go_closing", 2'd1);
        run_frames(9);
        check_state("go_back_open", 2'd0);
        run_frames(89);
        check_state("go_restart_f89", 2'd0);
        do_frame(1'b0);
        check_state("go_restart_f90", 2'd1);
        run_frames(9);
        check_state("go_restart_done", 2'd0);

        // go during S_CLOSED is held and starts a second blink.
        pulse_go();
        do_frame(1'b0);
        check_state("hold_closing", 2'd1);
        run_frames(3);
        check_state("hold_closed", 2'd2);
        pulse_go();
        run_frames(3);
        check_state("hold_opening", 2'd3);
        run_frames(3);
        check_state("hold_open", 2'd0);
        do_frame(1'b0);
        check_state("hold_second_blink", 2'd1);
        run_frames(9);
        check_state("hold_second_done", 2'd0);
        do_frame(1'b0);
        check_state("hold_pending_cleared", 2'd0);

        // go in the same cycle as the clearing tick stays pending.
        pulse_go();
        do_frame(1'b1);
        check_state("same_cycle_closing", 2'd1);
        run_frames(9);
        check_state("same_cycle_open", 2'd0);
        do_frame(1'b0);
        check_state("same_cycle_reblink", 2'd1);
        run_frames(9);
        check_state("same_cycle_done", 2'd0);

        // Reset mid-frame while closed with a go pending.
        pulse_go();
        do_frame(1'b0);
        run_frames(3);
        check_state("pre_reset_closed", 2'd2);
        pulse_go();
        ram_addr_x = 8'd40;
        ram_addr_y = 8'd66;
        rst = 1'b1;
        step();
        check_state("rst_state", 2'd0);
        check("rst_data", ram_data, 16'h2935);
        check("rst_tick", {15'd0, frame_tick}, 16'd0);
        rst = 1'b0;
        step();
        check("post_rst_open_eye", ram_data, 16'hFFFF);
        do_frame(1'b0);
        check_state("post_rst_no_pending", 2'd0);
        run_frames(88);
        check_state("post_rst_f89", 2'd0);
        do_frame(1'b0);
        check_state("post_rst_f90", 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
